// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Holds one byte for the consumer; sticky frame and overrun flags.
module uart_receiver #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV_R = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  logic          s1_q;
  logic          rx_s;
  logic [DW-1:0] div_q, div_d;
  logic          tick;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    smp_q, smp_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;

  logic          maj;
  logic          deliver;
  logic          fe_set;
  logic          ov_set;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1_q <= rx;
      rx_s <= s1_q;
    end
  end

  assign tick  = (div_q == DW'(DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  assign maj = (smp_q[0] & smp_q[1]) |
               (smp_q[0] & rx_s) |
               (smp_q[1] & rx_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    smp_d   = smp_q;
    sh_d    = sh_q;
    deliver = 1'b0;
    fe_set  = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = 4'd0;
          end
        end
        START, DATA, STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) smp_d[0] = rx_s;
          if (cnt_q == 4'd8) smp_d[1] = rx_s;
          if (cnt_q == 4'd9) begin
            unique case (state_q)
              START: begin
                if (maj) begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
                end
              end
              DATA: sh_d = {maj, sh_q[7:1]};
              default: begin
                // Stop bit ends the frame at mid-bit
                cnt_d = 4'd0;
                if (maj) begin
                  deliver = 1'b1;
                  state_d = IDLE;
                end else begin
                  fe_set  = 1'b1;
                  state_d = WAIT_HIGH;
                end
              end
            endcase
          end
          if (cnt_q == 4'd15) begin
            if (state_q == START) begin
              state_d = DATA;
              idx_d   = 3'd0;
            end else if (state_q == DATA) begin
              if (idx_q == 3'd7) state_d = STOP;
              else idx_d = idx_q + 3'd1;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_set  = 1'b0;
    if (deliver && (!valid_q || ack)) begin
      data_d  = sh_q;
      valid_d = 1'b1;
    end else if (deliver) begin
      ov_set  = 1'b1;
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
    fe_d = fe_q;
    ov_d = ov_q;
    if (err_clr) begin
      fe_d = 1'b0;
      ov_d = 1'b0;
    end
    if (fe_set) fe_d = 1'b1;
    if (ov_set) ov_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      smp_q   <= 2'b11;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning the frequency of clk in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high; in the SoC it is the UART receive pin.
REQ-006 The block SHALL have port data, output, 8 bits: the last accepted byte, feeding the reprogramming loader.
REQ-007 The block SHALL have port valid, output, 1 bit: data holds an unconsumed byte.
REQ-008 The block SHALL have port ack, input, 1 bit: the consumer takes data in any cycle where valid&ack.
REQ-009 The block SHALL have port err_clr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-010 The block SHALL have port frame_err, output, 1 bit: sticky flag, set when a stop bit is sampled low.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a byte is lost because valid was still high.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; the FSM SHALL use only the synchronized value rx_s.
REQ-014 DIV SHALL be round(CLK_HZ/(16*BAUD)), with a minimum of 1; for the defaults DIV = 54.
REQ-015 A free-running counter SHALL count 0..DIV-1 and pulse tick for one cycle at DIV-1; with DIV=1, tick is high every cycle.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH; a 4-bit sample counter cnt and a 3-bit bit index SHALL advance only on tick.
REQ-017 IDLE: on tick with rx_s=0, the FSM SHALL go to START with cnt=0.
REQ-018 Bit decision: rx_s SHALL be sampled at cnt=7, 8 and 9, and the bit value SHALL be the majority of the three, decided at cnt=9.
REQ-019 START: a majority of 1 SHALL return the FSM to IDLE (false start, nothing reported); otherwise, at cnt=15, the FSM SHALL go to DATA with bit index 0.
REQ-020 DATA: 8 bits SHALL be received LSB first, each lasting 16 ticks, and shifted into a holding register; after bit 7 at cnt=15 the FSM SHALL go to STOP.
REQ-021 STOP: at cnt=9, a majority of 1 SHALL deliver the byte and return the FSM to IDLE immediately, without waiting for cnt=15.
REQ-022 STOP: at cnt=9, a majority of 0 SHALL discard the byte, set frame_err and go to WAIT_HIGH.
REQ-023 WAIT_HIGH SHALL stay until rx_s=1 on a tick, then go to IDLE.
REQ-024 Delivery with valid=0, or with valid&ack in the same cycle: data SHALL load the new byte and valid SHALL be 1 from the next cycle.
REQ-025 Delivery with valid=1 and ack=0: the new byte SHALL be dropped, data SHALL be unchanged and overrun SHALL be set.
REQ-026 valid&ack with no delivery in the same cycle SHALL clear valid on the next cycle; data SHALL hold its value.
REQ-027 err_clr SHALL clear frame_err and overrun; a set event in the same cycle SHALL win.
REQ-028 With DIV=1, valid SHALL rise 155 +/-1 cycles after the rx falling edge of the start bit.

Reset
REQ-029 While rstn=0: state SHALL be IDLE; counters 0; data=0x00; valid, frame_err, overrun and busy SHALL be 0; synchronizer flops 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no delivery and no flag set.
REQ-031 After rstn release, the block SHALL wait for a fresh falling edge on rx before starting a frame.

Verification (CLK_HZ=16000, BAUD=1000, so DIV=1 and 16 clk per bit)
REQ-032 Send 0xA5 with a valid stop bit -> valid=1 at cycle 155+/-1, data=0xA5, frame_err=0, overrun=0; pulse ack -> valid=0 next cycle.
REQ-033 Leave valid=1 with ack=0, then send 0x3C -> overrun=1 and data stays 0xA5; pulse err_clr -> overrun=0.
REQ-034 Send 0x81 with the stop bit forced low and rx held low 40 cycles more -> frame_err=1, valid=0, busy=1 until rx returns high, then busy=0.
REQ-035 Drive a 4-cycle low glitch on rx -> no valid, no flag; busy returns to 0 within 12 cycles of the glitch.
REQ-036 Assert rstn=0 40 cycles into a frame, then release and send 0x5A -> all outputs 0 during reset, then data=0x5A, valid=1 and both flags 0.
REQ-037 Hold ack=1 in the exact cycle the next byte 0x77 is delivered, with valid=1 from the previous byte -> data=0x77, valid stays 1, overrun=0.
